// File: rtl/shape_pkg.sv
// Shared types and helpers for the shape-table controller: shape record,
// edit modes, step decode and default screen/angle bounds.
package shape_pkg;

  localparam int SHP_INTW    = 16;
  localparam int SHP_PIXLW   = 12;
  localparam int DEF_SCR_W   = 800;
  localparam int DEF_SCR_H   = 600;
  localparam int DEF_ANG_MIN = -180;
  localparam int DEF_ANG_MAX = 179;

  typedef struct packed {
    logic signed [SHP_INTW-1:0] x;
    logic signed [SHP_INTW-1:0] y;
    logic signed [SHP_INTW-1:0] size;
    logic signed [SHP_INTW-1:0] angle;
    logic        [SHP_INTW-1:0] ty;
    logic        [SHP_PIXLW-1:0] color;
  } shape_t;

  typedef enum logic [1:0] {
    MODE_MOVE  = 2'd0,
    MODE_SIZE  = 2'd1,
    MODE_SEL   = 2'd2,
    MODE_COLOR = 2'd3
  } mode_e;

  // mag 0..3 selects a step of 1, 4, 16 or 64
  function automatic logic [SHP_INTW-1:0] step_of(input logic [1:0] mag);
    return SHP_INTW'(1) << {mag, 1'b0};
  endfunction

endpackage

// File: rtl/shape_edit_ctrl_bounded_step.sv
// Signed value plus or minus a step, either clamped to [lo, hi] or wrapped
// around the inclusive range.
module bounded_step #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] value,
  input  logic        [W-1:0] step,
  input  logic                sub,
  input  logic                wrap,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  output logic signed [W-1:0] result
);

  logic signed [W:0] sum;
  logic signed [W:0] lo_x;
  logic signed [W:0] hi_x;
  logic signed [W:0] span;
  logic signed [W:0] adj;

  // one extra bit keeps the overshoot visible before clamp/wrap
  always_comb begin
    lo_x = {lo[W-1], lo};
    hi_x = {hi[W-1], hi};
    span = hi_x - lo_x + (W+1)'(1);
    sum  = sub ? ({value[W-1], value} - {1'b0, step})
               : ({value[W-1], value} + {1'b0, step});
    adj  = sum;
    if (sum < lo_x)
      adj = wrap ? (sum + span) : lo_x;
    else if (sum > hi_x)
      adj = wrap ? (sum - span) : hi_x;
    result = adj[W-1:0];
  end

endmodule

// File: rtl/shape_edit_ctrl.sv
// Per-frame shape-table editor: applies one edit per frame to the selected
// shape, then sweeps every live shape through the coefficient handshake.
module shape_edit_ctrl
  import shape_pkg::*;
#(
  parameter int MAXSHP   = 16,
  parameter int IDW      = $clog2(MAXSHP),
  parameter int INTW     = SHP_INTW,
  parameter int PIXLW    = SHP_PIXLW,
  parameter int SCR_W    = DEF_SCR_W,
  parameter int SCR_H    = DEF_SCR_H,
  parameter int SIZE_MAX = 255,
  parameter int NTYPE    = 4,
  parameter int ANG_MIN  = DEF_ANG_MIN,
  parameter int ANG_MAX  = DEF_ANG_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_end,
  input  logic [1:0]             mode,
  input  logic                   btn_l,
  input  logic                   btn_r,
  input  logic                   btn_u,
  input  logic                   btn_d,
  input  logic                   btn_l_once,
  input  logic                   btn_r_once,
  input  logic                   btn_c_once,
  input  logic [1:0]             mag,
  input  logic [PIXLW-1:0]       pick_color,
  input  logic [IDW-1:0]         rd_id,
  output logic signed [INTW-1:0] rd_x,
  output logic signed [INTW-1:0] rd_y,
  output logic signed [INTW-1:0] rd_size,
  output logic signed [INTW-1:0] rd_angle,
  output logic [INTW-1:0]        rd_ty,
  output logic [PIXLW-1:0]       rd_color,
  output logic [IDW-1:0]         sel,
  output logic [IDW:0]           count,
  output logic                   cf_req,
  output logic [IDW-1:0]         cf_id,
  output logic signed [INTW-1:0] cf_x,
  output logic signed [INTW-1:0] cf_y,
  output logic signed [INTW-1:0] cf_angle,
  input  logic                   cf_ack,
  output logic                   edit_done,
  output logic                   busy,
  output logic [7:0]             overrun
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EDIT  = 2'd1;
  localparam logic [1:0] ST_SWREQ = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [IDW:0] CNT_ONE = (IDW+1)'(1);
  localparam logic [IDW:0] CNT_MAX = (IDW+1)'(MAXSHP);

  logic [1:0]             state;
  logic [IDW-1:0]         idx;
  shape_t                 tbl [MAXSHP];
  mode_e                  mode_m;
  shape_t                 cur;
  shape_t                 edit_slot;
  logic [INTW-1:0]        step;
  logic signed [INTW-1:0] st_val, st_lo, st_hi, st_res;
  logic                   st_sub, st_wrap;
  logic                   upd_x, upd_y, upd_sz, upd_ang;
  logic [IDW-1:0]         sel_n;
  logic [IDW:0]           cnt_n;
  logic                   cw_en;
  logic [IDW-1:0]         cw_idx;
  logic [PIXLW-1:0]       cw_color;

  assign mode_m = mode_e'(mode);

  bounded_step #(.W(INTW)) u_step (
    .value  (st_val),
    .step   (step),
    .sub    (st_sub),
    .wrap   (st_wrap),
    .lo     (st_lo),
    .hi     (st_hi),
    .result (st_res)
  );

  // One stepper serves all fields, so L/R takes the frame when pressed with U/D
  always_comb begin
    cur     = tbl[sel];
    step    = INTW'(step_of(mag));
    st_val  = '0;
    st_lo   = '0;
    st_hi   = '0;
    st_sub  = 1'b0;
    st_wrap = 1'b0;
    upd_x   = 1'b0;
    upd_y   = 1'b0;
    upd_sz  = 1'b0;
    upd_ang = 1'b0;
    case (mode_m)
      MODE_MOVE: begin
        if (btn_l || btn_r) begin
          st_val = cur.x; st_hi = INTW'(SCR_W - 1); st_sub = btn_l; upd_x = 1'b1;
        end else if (btn_u || btn_d) begin
          st_val = cur.y; st_hi = INTW'(SCR_H - 1); st_sub = btn_u; upd_y = 1'b1;
        end
      end
      MODE_SIZE: begin
        if (btn_l || btn_r) begin
          st_val = cur.angle; st_lo = INTW'(ANG_MIN); st_hi = INTW'(ANG_MAX);
          st_sub = btn_l; st_wrap = 1'b1; upd_ang = 1'b1;
        end else if (btn_u || btn_d) begin
          st_val = cur.size; st_hi = INTW'(SIZE_MAX); st_sub = ~btn_u; upd_sz = 1'b1;
        end
      end
      default: ;
    endcase

    edit_slot = cur;
    if (upd_x)   edit_slot.x     = st_res;
    if (upd_y)   edit_slot.y     = st_res;
    if (upd_sz)  edit_slot.size  = st_res;
    if (upd_ang) edit_slot.angle = st_res;
    if (mode_m == MODE_SIZE && btn_c_once)
      edit_slot.ty = (cur.ty == INTW'(NTYPE - 1)) ? '0 : cur.ty + 1'b1;
    if (mode_m == MODE_COLOR && btn_c_once)
      edit_slot.color = pick_color;
  end

  // Add/remove/select; select sees the count after this frame's add/remove
  always_comb begin
    sel_n    = sel;
    cnt_n    = count;
    cw_en    = 1'b0;
    cw_idx   = '0;
    cw_color = '0;
    if (mode_m == MODE_SEL) begin
      if (btn_l_once) begin
        if (count > CNT_ONE) begin
          cw_en  = 1'b1;
          cw_idx = IDW'(count - 1'b1);
          cnt_n  = count - 1'b1;
          if ({1'b0, sel} == count - 1'b1) sel_n = IDW'(count - 2'd2);
        end
      end else if (btn_r_once && count < CNT_MAX) begin
        cw_en    = 1'b1;
        cw_idx   = IDW'(count);
        cw_color = '1;
        sel_n    = IDW'(count);
        cnt_n    = count + 1'b1;
      end
      if (btn_c_once)
        sel_n = (({1'b0, sel_n} + 1'b1) == cnt_n) ? '0 : sel_n + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      sel     <= '0;
      count   <= CNT_ONE;
      overrun <= '0;
      cf_req  <= 1'b0;
      for (int k = 0; k < MAXSHP; k++) tbl[k] <= '0;
      tbl[0].color <= '1;
    end else begin
      if (frame_end && state != ST_IDLE && overrun != 8'hFF)
        overrun <= overrun + 1'b1;
      case (state)
        ST_IDLE: if (frame_end) state <= ST_EDIT;
        ST_EDIT: begin
          if (mode_m == MODE_SEL) begin
            if (cw_en) tbl[cw_idx].color <= cw_color;
          end else begin
            tbl[sel] <= edit_slot;
          end
          sel    <= sel_n;
          count  <= cnt_n;
          idx    <= '0;
          cf_req <= 1'b1;
          state  <= ST_SWREQ;
        end
        // Every ack is followed by one idle-request cycle before the next step
        ST_SWREQ: begin
          if (cf_req) begin
            if (cf_ack) cf_req <= 1'b0;
          end else if ({1'b0, idx} == count - 1'b1) begin
            state <= ST_DONE;
          end else begin
            idx    <= idx + 1'b1;
            cf_req <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_x      = tbl[rd_id].x;
  assign rd_y      = tbl[rd_id].y;
  assign rd_size   = tbl[rd_id].size;
  assign rd_angle  = tbl[rd_id].angle;
  assign rd_ty     = tbl[rd_id].ty;
  assign rd_color  = tbl[rd_id].color;
  assign cf_id     = idx;
  assign cf_x      = tbl[idx].x;
  assign cf_y      = tbl[idx].y;
  assign cf_angle  = tbl[idx].angle;
  assign busy      = (state != ST_IDLE);
  assign edit_done = (state == ST_DONE);

endmodule

// File: tb/tb_shape_edit_ctrl.sv
// Bench for shape_edit_ctrl: directed frames against an integer model of the
// shape table, with a per-cycle compare of the read port and sweep handshake.
module tb_shape_edit_ctrl;

  localparam bit [6:0] B_L  = 7'b1000000;
  localparam bit [6:0] B_R  = 7'b0100000;
  localparam bit [6:0] B_U  = 7'b0010000;
  localparam bit [6:0] B_D  = 7'b0001000;
  localparam bit [6:0] B_LO = 7'b0000100;
  localparam bit [6:0] B_RO = 7'b0000010;
  localparam bit [6:0] B_CO = 7'b0000001;
  localparam bit [6:0] B_NO = 7'b0000000;

  logic clk = 1'b0, rst_n = 1'b0, frame_end = 1'b0;
  logic [1:0] mode = 2'd0, mag = 2'd0;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic btn_l_once = 1'b0, btn_r_once = 1'b0, btn_c_once = 1'b0;
  logic [11:0] pick_color = 12'h000;
  logic [3:0] rd_id = 4'd0;
  logic signed [15:0] rd_x, rd_y, rd_size, rd_angle, cf_x, cf_y, cf_angle;
  logic [15:0] rd_ty;
  logic [11:0] rd_color;
  logic [3:0] sel, cf_id;
  logic [4:0] count;
  logic cf_req, cf_ack = 1'b0, edit_done, busy;
  logic [7:0] overrun;

  shape_edit_ctrl #(.MAXSHP(16)) dut (
    .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .mode(mode),
    .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .btn_l_once(btn_l_once), .btn_r_once(btn_r_once), .btn_c_once(btn_c_once),
    .mag(mag), .pick_color(pick_color), .rd_id(rd_id),
    .rd_x(rd_x), .rd_y(rd_y), .rd_size(rd_size), .rd_angle(rd_angle),
    .rd_ty(rd_ty), .rd_color(rd_color), .sel(sel), .count(count),
    .cf_req(cf_req), .cf_id(cf_id), .cf_x(cf_x), .cf_y(cf_y), .cf_angle(cf_angle),
    .cf_ack(cf_ack), .edit_done(edit_done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int mx[16], my[16], msz[16], mang[16], mty[16], mcol[16];
  int msel, mcnt, movr;
  int exp_id = 0, done_cnt = 0, ack_cyc = 0, wait_n = 0;
  int dly_tab[4] = '{0, 0, 0, 0};
  bit hold_ack = 1'b0, prev_ack = 1'b0, prev_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      mx[k] = 0; my[k] = 0; msz[k] = 0; mang[k] = 0; mty[k] = 0; mcol[k] = 0;
    end
    mcol[0] = 12'hFFF;
    msel = 0; mcnt = 1; movr = 0;
  endtask

  task automatic model_edit(input int md, input int mg, input bit [6:0] b, input int pc);
    int s, a;
    bit l, r, u, d, lo, ro, co;
    {l, r, u, d, lo, ro, co} = b;
    s = 1 << (2 * mg);
    case (md)
      0: begin
        if (l || r) mx[msel] = clampi(mx[msel] + (l ? -s : s), 0, 799);
        else if (u || d) my[msel] = clampi(my[msel] + (u ? -s : s), 0, 599);
      end
      1: begin
        if (l || r) begin
          a = mang[msel] + (l ? -s : s);
          if (a < -180) a += 360;
          else if (a > 179) a -= 360;
          mang[msel] = a;
        end else if (u || d) msz[msel] = clampi(msz[msel] + (u ? s : -s), 0, 255);
        if (co) mty[msel] = (mty[msel] + 1) % 4;
      end
      2: begin
        if (lo) begin
          if (mcnt > 1) begin
            mcol[mcnt-1] = 0;
            mcnt--;
            if (msel == mcnt) msel = mcnt - 1;
          end
        end else if (ro && mcnt < 16) begin
          mcol[mcnt] = 12'hFFF;
          msel = mcnt;
          mcnt++;
        end
        if (co) msel = (msel + 1) % mcnt;
      end
      default: if (co) mcol[msel] = pc;
    endcase
  endtask

  // Coefficient unit stand-in: acks after dly_tab[cf_id] waiting cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      cf_ack = 1'b0;
      if (rst_n && cf_req && !hold_ack) begin
        if (wait_n < dly_tab[cf_id % 4]) wait_n++;
        else begin cf_ack = 1'b1; wait_n = 0; ack_cyc = cyc; end
      end else wait_n = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_id = 0; prev_ack = 1'b0; prev_gap = 1'b0;
    end else begin
      if (prev_gap) check("req_or_done_after_gap", int'(cf_req || edit_done), 1);
      prev_gap = prev_ack;
      if (prev_ack) check("cf_req_gap", int'(cf_req), 0);
      if (cf_req) begin
        check("cf_id", int'(cf_id), exp_id);
        check("cf_x", int'(cf_x), mx[exp_id % 16]);
        check("cf_y", int'(cf_y), my[exp_id % 16]);
        check("cf_angle", int'(cf_angle), mang[exp_id % 16]);
      end
      prev_ack = cf_req && cf_ack;
      if (prev_ack) exp_id++;
      if (edit_done) begin
        done_cnt++;
        check("sweep_len", exp_id, mcnt);
        check("done_latency", cyc - ack_cyc, 2);
        exp_id = 0;
      end
      if (!busy) begin
        check("sel", int'(sel), msel);
        check("count", int'(count), mcnt);
        check("overrun", int'(overrun), movr);
        check("rd_x", int'(rd_x), mx[rd_id]);
        check("rd_y", int'(rd_y), my[rd_id]);
        check("rd_size", int'(rd_size), msz[rd_id]);
        check("rd_angle", int'(rd_angle), mang[rd_id]);
        check("rd_ty", int'(rd_ty), mty[rd_id]);
        check("rd_color", int'(rd_color), mcol[rd_id]);
        rd_id = rd_id + 4'd1;
      end
    end
  end

  task automatic start_frame(input int md, input int mg, input bit [6:0] b, input int pc);
    @(negedge clk);
    mode = 2'(md); mag = 2'(mg); pick_color = 12'(pc);
    {btn_l, btn_r, btn_u, btn_d, btn_l_once, btn_r_once, btn_c_once} = b;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    @(posedge clk); #1;
    model_edit(md, mg, b, pc);
    {btn_l, btn_r, btn_u, btn_d, btn_l_once, btn_r_once, btn_c_once} = 7'b0;
  endtask

  task automatic wait_done(input int st);
    int k;
    k = 0;
    while (done_cnt == st && k < 400) begin @(posedge clk); k++; end
    check("sweep_finished", done_cnt - st, 1);
    @(posedge clk); #1;
    check("edit_done_once", done_cnt - st, 1);
  endtask

  task automatic run_frame(input int md, input int mg, input bit [6:0] b, input int pc);
    int st;
    st = done_cnt;
    start_frame(md, mg, b, pc);
    wait_done(st);
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (!cf_req && k < 50) begin @(negedge clk); k++; end
    check("req_seen", int'(cf_req), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int st;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sel", int'(sel), 0);
    check("rst_count", int'(count), 1);
    check("rst_overrun", int'(overrun), 0);
    check("rst_cf_req", int'(cf_req), 0);
    check("rst_edit_done", int'(edit_done), 0);
    check("rst_busy", int'(busy), 0);
    check("model_color0", mcol[0], 4095);
    idle(17);

    // Reset in the middle of a sweep
    hold_ack = 1'b1;
    start_frame(3, 0, B_NO, 0);
    wait_req();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midsweep_cf_req", int'(cf_req), 0);
    check("midsweep_busy", int'(busy), 0);
    model_reset();
    hold_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(3, 0, B_NO, 0);

    // Move with clamp
    repeat (12) run_frame(0, 3, B_R, 0);
    repeat (1)  run_frame(0, 2, B_R, 0);
    repeat (1)  run_frame(0, 1, B_R, 0);
    repeat (2)  run_frame(0, 0, B_R, 0);
    check("model_x790", mx[0], 790);
    run_frame(0, 2, B_R, 0);
    check("model_x_clamp", mx[0], 799);
    repeat (3) run_frame(0, 0, B_D, 0);
    run_frame(0, 1, B_U, 0);
    check("model_y_clamp", my[0], 0);
    idle(17);

    // Angle wrap, size saturation, type cycling
    repeat (2) run_frame(1, 3, B_R, 0);
    repeat (2) run_frame(1, 2, B_R, 0);
    repeat (3) run_frame(1, 1, B_R, 0);
    repeat (3) run_frame(1, 0, B_R, 0);
    check("model_ang175", mang[0], 175);
    run_frame(1, 1, B_R, 0);
    check("model_ang179", mang[0], 179);
    run_frame(1, 1, B_R, 0);
    check("model_ang_wrap_hi", mang[0], -177);
    repeat (3) run_frame(1, 0, B_L, 0);
    run_frame(1, 0, B_L, 0);
    check("model_ang_wrap_lo", mang[0], 179);
    repeat (5) run_frame(1, 3, B_U, 0);
    check("model_size_sat", msz[0], 255);
    run_frame(1, 3, B_D, 0);
    repeat (5) run_frame(1, 0, B_CO, 0);
    check("model_ty", mty[0], 1);
    run_frame(3, 0, B_CO, 12'h5A3);
    check("model_color", mcol[0], 12'h5A3);
    idle(17);

    // Add to the limit, then remove
    repeat (16) run_frame(2, 0, B_RO, 0);
    check("count_full", int'(count), 16);
    check("sel_full", int'(sel), 15);
    check("model_color15", mcol[15], 4095);
    idle(17);
    run_frame(2, 0, B_LO, 0);
    check("count_rm", int'(count), 15);
    check("sel_rm", int'(sel), 14);
    check("model_color15_rm", mcol[15], 0);
    repeat (12) run_frame(2, 0, B_LO, 0);
    check("count_3", int'(count), 3);
    check("sel_2", int'(sel), 2);
    run_frame(0, 1, B_R, 0);
    run_frame(1, 2, B_L, 0);
    idle(17);

    // Three-shape sweep with staggered acks
    dly_tab = '{0, 5, 2, 0};
    run_frame(3, 0, B_NO, 0);
    dly_tab = '{0, 0, 0, 0};

    // Select wraps at count
    run_frame(2, 0, B_CO, 0);
    check("sel_wrap", int'(sel), 0);

    // Frame pulses dropped while busy
    hold_ack = 1'b1;
    st = done_cnt;
    start_frame(3, 0, B_NO, 0);
    wait_req();
    repeat (3) begin
      @(negedge clk); frame_end = 1'b1;
      @(negedge clk); frame_end = 1'b0;
      movr++;
    end
    @(negedge clk);
    check("overrun_3", int'(overrun), 3);
    check("overrun_busy", int'(busy), 1);
    check("overrun_cf_req", int'(cf_req), 1);
    check("overrun_cf_id", int'(cf_id), 0);
    hold_ack = 1'b0;
    wait_done(st);
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_chk++;
    n_fail++;
    $display("FAIL timeout: got no completion expected finish before limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shape_edit_ctrl.md
Name: shape_edit_ctrl

Overview:
- Per-frame shape-table controller for the tangram renderer; generalises the single-shape editor to any selected shape of MAXSHP.
- Adds step magnitudes, add/remove/select of shapes, and a handshaked coefficient-precompute sweep over live shapes only.
- Sits between the debounced button/mode logic and the render_shape array plus the coefficient unit (sin/cos/rotate).
- Owns the shape table and exposes it through a combinational read port.

Parameters:
- MAXSHP, 16, shape slots; must be ≥ 2.
- IDW, $clog2(MAXSHP), shape-index width.
- INTW, 16, integer field width (x, y, size, angle; angle is signed).
- PIXLW, 12, colour width (RGB444).
- SCR_W, 800, x upper bound is SCR_W-1.
- SCR_H, 600, y upper bound is SCR_H-1.
- SIZE_MAX, 255, size saturation limit.
- NTYPE, 4, number of shape types.
- ANG_MIN, -180, inclusive lower angle.
- ANG_MAX, 179, inclusive upper angle.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_end  in  1  one-cycle end-of-active-frame pulse.
- mode  in  2  0 move, 1 size/rotate/type, 2 add/remove/select, 3 colour.
- btn_l, btn_r, btn_u, btn_d  in  1 each  repeat-qualified press.
- btn_l_once, btn_r_once, btn_c_once  in  1 each  single-shot press.
- mag  in  2  step select: 0→1, 1→4, 2→16, 3→64.
- pick_color  in  PIXLW  colour-picker value.
- rd_id  in  IDW  table read index.
- rd_x, rd_y, rd_size, rd_angle  out  INTW each  fields of slot rd_id.
- rd_ty  out  INTW  type of slot rd_id.
- rd_color  out  PIXLW  colour of slot rd_id.
- sel  out  IDW  selected shape.
- count  out  IDW+1  number of live shapes.
- cf_req  out  1  coefficient request.
- cf_id  out  IDW  coefficient request index.
- cf_x, cf_y, cf_angle  out  INTW each  coefficient request payload.
- cf_ack  in  1  coefficient accepted/computed.
- edit_done  out  1  one-cycle pulse at sweep end; clears button latches.
- busy  out  1  high whenever state ≠ IDLE.
- overrun  out  8  saturating count of frame_end pulses dropped while busy.

Behaviour:
Reset (async assert, sync deassert):
- State → IDLE; sel=0, count=1, overrun=0, cf_req=0, edit_done=0.
- All slots: x=y=size=angle=ty=0.
- color[0]=12'hFFF; all other slots 0.
- Reset mid-sweep drops cf_req immediately and discards the sweep.

States:
- IDLE: frame_end → EDIT.
- EDIT: one cycle; applies the mode action to slot sel; → SW_REQ with i=0.
- SW_REQ: cf_req=1 with {cf_id=i, fields of slot i} held stable until cf_ack.
  - On cf_ack: if i==count-1 → DONE, else i+1 and stay in SW_REQ.
  - cf_req deasserts for exactly one cycle between requests.
- DONE: edit_done=1 for one cycle → IDLE.
- frame_end while busy: no effect on state; overrun++ (saturates at 255).

Mode 0 (move, applied to slot sel):
- Step s = 1 << (2*mag).
- U/D: y -= s or y += s, clamped to [0, SCR_H-1]. L/R: x, same rule, clamped to [0, SCR_W-1].
- U beats D; L beats R.

Mode 1 (size/rotate/type):
- L/R: angle ∓ s with wrap; result < ANG_MIN adds 360, result > ANG_MAX subtracts 360.
- U/D: size ± s, saturating to [0, SIZE_MAX].
- c_once: ty = (ty==NTYPE-1) ? 0 : ty+1.

Mode 2 (add/remove/select; _once inputs only):
- r_once and count<MAXSHP: color[count]=FFF, sel=count, count+1.
- l_once and count>1: color[count-1]=0, count-1; if sel==count-1 then sel=count-2.
- c_once: sel=(sel+1) mod count.
- l beats r; c is evaluated after add/remove, using the updated count.

Mode 3 (colour):
- c_once: color[sel]=pick_color.

Arithmetic and latency:
- Clamp compares use INTW+1-bit signed intermediates so nothing wraps.
- Read port is combinational.
- Edit-to-visible latency: one EDIT cycle plus count handshakes, within the same vblank.

Decomposition:
- shape_pkg holds:
  - shape_t struct {x, y, size, angle, ty, color};
  - mode_e enum;
  - the step-decode function;
  - default SCR_W/SCR_H/ANG bounds.
- Sub-module bounded_step: signed value ± step with clamp or wrap selectable by an input (replaces circular_step). Instantiated once for x/y/size/angle, muxed by mode.

Test Plan:
- Reset, then sweep: rst_n low mid-sweep → cf_req=0 same cycle; after release, frame_end → one request (cf_id=0), edit_done 2 cycles after cf_ack.
- Move clamp: mode 0, mag=2, x=790, btn_r for one frame → x=799; y=3, btn_u, mag=1 → y=0.
- Angle wrap: mode 1, angle=175, mag=1, btn_r → angle=-181+360=179? no: 175+4=179 stays; then btn_r again → -177; angle=-180, btn_l, mag=0 → 179.
- Add/remove: mode 2, r_once ×16 from reset → count saturates at 16, sel=15, color[15]=FFF; l_once → count=15, sel=14, color[15]=0.
- Sweep handshake: count=3, cf_ack delayed 0/5/2 cycles → cf_id 0,1,2 in order, payload stable while cf_req high, edit_done exactly once.
- Overrun: hold cf_ack low, issue 3 frame_end pulses → overrun=3, state unchanged; select via c_once at count=3, sel=2 → sel=0.
